// File: rtl/complex_div_pkg.sv
// Shared constants, types and helpers for the iterative complex divider.
// COMPLEX_DIV_ROUND_EN selects round-half-away-from-zero (one extra iteration).
package complex_div_pkg;

  localparam int unsigned AW   = 16;
  localparam int unsigned BW   = 16;
  localparam int unsigned QW   = 16;
  localparam int unsigned FRAC = 8;

  localparam int unsigned NW = AW + BW + 1;  // signed numerator width
  localparam int unsigned MW = NW - 1;       // numerator magnitude width
  localparam int unsigned DW = 2 * BW;       // denominator width
  localparam int unsigned SH = QW - 1 - FRAC;
  localparam int unsigned SW = DW + SH;      // saturation compare width

`ifdef COMPLEX_DIV_ROUND_EN
  localparam int unsigned NITER = QW;
`else
  localparam int unsigned NITER = QW - 1;
`endif

  // Left shift applied to |num| before division (FRAC, plus one guard bit when rounding)
  localparam int unsigned DSH = NITER - SH;

  localparam logic [QW-1:0] SAT_MAG = QW'((2 ** (QW - 1)) - 1);

  typedef enum logic [1:0] {IDLE, PREP, DIV, DONE} state_e;

  typedef struct packed {
    logic [QW-1:0] q_re;
    logic [QW-1:0] q_im;
    logic          dz;
    logic          ovf;
  } result_t;

  function automatic logic [QW-1:0] apply_sign(input logic neg, input logic [QW-1:0] mag);
    return neg ? QW'(-mag) : mag;
  endfunction

endpackage

// File: rtl/complex_div_udiv_iter.sv
// Unsigned restoring divider: floor((num << DSH) / den), one quotient bit per cycle.
// The first iteration happens on the start edge; done pulses with the last bit.
module complex_div_udiv_iter
  import complex_div_pkg::*;
#(
  parameter int unsigned P_MW    = MW,
  parameter int unsigned P_DW    = DW,
  parameter int unsigned P_NITER = NITER,
  parameter int unsigned P_DSH   = DSH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [P_MW-1:0]    num,
  input  logic [P_DW-1:0]    den,
  output logic               busy,
  output logic               done,
  output logic [P_NITER-1:0] quo
);

  localparam int unsigned EW = P_MW + P_DSH;
  localparam int unsigned CW = $clog2(P_NITER + 1);

  logic [P_DW-1:0]    rem_q, rem_d;
  logic [P_NITER-1:0] lo_q, lo_d;
  logic [P_NITER-1:0] quo_q, quo_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [EW-1:0]      ext_c;
  logic [P_DW-1:0]    rem_src_c;
  logic [P_NITER-1:0] lo_src_c;
  logic [P_NITER-1:0] quo_src_c;
  logic [P_DW:0]      trial_c;

  // One restoring step, sourced from the fresh dividend on start
  always_comb begin
    ext_c     = EW'(num) << P_DSH;
    rem_src_c = start ? P_DW'(ext_c >> P_NITER) : rem_q;
    lo_src_c  = start ? ext_c[P_NITER-1:0] : lo_q;
    quo_src_c = start ? '0 : quo_q;
    trial_c   = {rem_src_c, lo_src_c[P_NITER-1]};

    rem_d  = rem_q;
    lo_d   = lo_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;

    if (start || busy_q) begin
      lo_d = lo_src_c << 1;
      if (trial_c >= {1'b0, den}) begin
        rem_d = P_DW'(trial_c - {1'b0, den});
        quo_d = {quo_src_c[P_NITER-2:0], 1'b1};
      end else begin
        rem_d = P_DW'(trial_c);
        quo_d = {quo_src_c[P_NITER-2:0], 1'b0};
      end
      if (start) begin
        cnt_d  = CW'(P_NITER - 1);
        busy_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      lo_q   <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      lo_q   <= lo_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign quo  = quo_q;

endmodule

// File: rtl/complex_div.sv
// Iterative complex divider q = a / b with FRAC fractional quotient bits, valid/ready both sides.
// COMPLEX_DIV_ROUND_EN: round half away from zero instead of truncating (latency +1).
module complex_div
  import complex_div_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [AW-1:0] a_re,
  input  logic signed [AW-1:0] a_im,
  input  logic signed [BW-1:0] b_re,
  input  logic signed [BW-1:0] b_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [QW-1:0] q_re,
  output logic signed [QW-1:0] q_im,
  output logic                 dz,
  output logic                 ovf
);

  state_e               state_q, state_d;
  logic signed [AW-1:0] a_re_q, a_re_d, a_im_q, a_im_d;
  logic signed [BW-1:0] b_re_q, b_re_d, b_im_q, b_im_d;
  logic [DW-1:0]        den_q, den_d;
  logic [MW-1:0]        mag_re_q, mag_re_d, mag_im_q, mag_im_d;
  logic                 neg_re_q, neg_re_d, neg_im_q, neg_im_d;
  logic                 sat_re_q, sat_re_d, sat_im_q, sat_im_d;
  logic                 dz_flag_q, dz_flag_d;
  logic                 start_pend_q, start_pend_d;
  result_t              res_q, res_d;
  logic                 out_valid_q, out_valid_d;
  logic                 in_ready_q, in_ready_d;

  logic signed [NW-1:0] ar_x, ai_x, br_x, bi_x;
  logic signed [NW-1:0] num_re_c, num_im_c;
  logic [BW-1:0]        bm_re_c, bm_im_c;
  logic [DW-1:0]        den_c;
  logic [MW-1:0]        mag_re_c, mag_im_c;
  logic                 sat_re_c, sat_im_c;
  logic [QW-1:0]        fin_re_c, fin_im_c;
  logic                 rsat_re_c, rsat_im_c;
  logic                 start_c;
  logic                 div_idle_c;

  logic                 busy_re, busy_im, done_re, done_im;
  logic [NITER-1:0]     quo_re, quo_im;

  // Numerators, denominator and per-component saturation pre-check
  always_comb begin
    ar_x     = NW'(a_re_q);
    ai_x     = NW'(a_im_q);
    br_x     = NW'(b_re_q);
    bi_x     = NW'(b_im_q);
    num_re_c = ar_x * br_x + ai_x * bi_x;
    num_im_c = ai_x * br_x - ar_x * bi_x;
    bm_re_c  = b_re_q[BW-1] ? BW'(-b_re_q) : BW'(b_re_q);
    bm_im_c  = b_im_q[BW-1] ? BW'(-b_im_q) : BW'(b_im_q);
    den_c    = DW'(bm_re_c) * DW'(bm_re_c) + DW'(bm_im_c) * DW'(bm_im_c);
    mag_re_c = MW'(num_re_c[NW-1] ? -num_re_c : num_re_c);
    mag_im_c = MW'(num_im_c[NW-1] ? -num_im_c : num_im_c);
    sat_re_c = SW'(mag_re_c) >= (SW'(den_c) << SH);
    sat_im_c = SW'(mag_im_c) >= (SW'(den_c) << SH);
  end

  // Final quotient magnitude; the rounded form may still hit 2^(QW-1)
  always_comb begin
`ifdef COMPLEX_DIV_ROUND_EN
    fin_re_c  = QW'(quo_re >> 1) + QW'(quo_re[0]);
    fin_im_c  = QW'(quo_im >> 1) + QW'(quo_im[0]);
    rsat_re_c = fin_re_c[QW-1];
    rsat_im_c = fin_im_c[QW-1];
`else
    fin_re_c  = QW'(quo_re);
    fin_im_c  = QW'(quo_im);
    rsat_re_c = 1'b0;
    rsat_im_c = 1'b0;
`endif
  end

  assign div_idle_c = ~(busy_re | busy_im);

  always_comb begin
    state_d      = state_q;
    a_re_d       = a_re_q;
    a_im_d       = a_im_q;
    b_re_d       = b_re_q;
    b_im_d       = b_im_q;
    den_d        = den_q;
    mag_re_d     = mag_re_q;
    mag_im_d     = mag_im_q;
    neg_re_d     = neg_re_q;
    neg_im_d     = neg_im_q;
    sat_re_d     = sat_re_q;
    sat_im_d     = sat_im_q;
    dz_flag_d    = dz_flag_q;
    start_pend_d = start_pend_q;
    res_d        = res_q;
    out_valid_d  = out_valid_q;
    in_ready_d   = in_ready_q;
    start_c      = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          a_re_d     = a_re;
          a_im_d     = a_im;
          b_re_d     = b_re;
          b_im_d     = b_im;
          in_ready_d = 1'b0;
          state_d    = PREP;
        end
      end
      PREP: begin
        den_d        = den_c;
        mag_re_d     = mag_re_c;
        mag_im_d     = mag_im_c;
        neg_re_d     = num_re_c[NW-1];
        neg_im_d     = num_im_c[NW-1];
        sat_re_d     = sat_re_c;
        sat_im_d     = sat_im_c;
        dz_flag_d    = (den_c == '0);
        start_pend_d = 1'b1;
        state_d      = DIV;
      end
      DIV: begin
        if (start_pend_q) begin
          // Divide-by-zero and full saturation finish without iterating
          if (dz_flag_q) begin
            start_pend_d = 1'b0;
            res_d.q_re   = '0;
            res_d.q_im   = '0;
            res_d.dz     = 1'b1;
            res_d.ovf    = 1'b0;
            out_valid_d  = 1'b1;
            state_d      = DONE;
          end else if (sat_re_q && sat_im_q) begin
            start_pend_d = 1'b0;
            res_d.q_re   = apply_sign(neg_re_q, SAT_MAG);
            res_d.q_im   = apply_sign(neg_im_q, SAT_MAG);
            res_d.dz     = 1'b0;
            res_d.ovf    = 1'b1;
            out_valid_d  = 1'b1;
            state_d      = DONE;
          end else begin
            start_c      = div_idle_c;
            start_pend_d = ~div_idle_c;
          end
        end else if (done_re && done_im) begin
          res_d.q_re  = (sat_re_q || rsat_re_c) ? apply_sign(neg_re_q, SAT_MAG)
                                                : apply_sign(neg_re_q, fin_re_c);
          res_d.q_im  = (sat_im_q || rsat_im_c) ? apply_sign(neg_im_q, SAT_MAG)
                                                : apply_sign(neg_im_q, fin_im_c);
          res_d.dz    = 1'b0;
          res_d.ovf   = sat_re_q | sat_im_q | rsat_re_c | rsat_im_c;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      a_re_q       <= '0;
      a_im_q       <= '0;
      b_re_q       <= '0;
      b_im_q       <= '0;
      den_q        <= '0;
      mag_re_q     <= '0;
      mag_im_q     <= '0;
      neg_re_q     <= 1'b0;
      neg_im_q     <= 1'b0;
      sat_re_q     <= 1'b0;
      sat_im_q     <= 1'b0;
      dz_flag_q    <= 1'b0;
      start_pend_q <= 1'b0;
      res_q        <= '0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_re_q       <= a_re_d;
      a_im_q       <= a_im_d;
      b_re_q       <= b_re_d;
      b_im_q       <= b_im_d;
      den_q        <= den_d;
      mag_re_q     <= mag_re_d;
      mag_im_q     <= mag_im_d;
      neg_re_q     <= neg_re_d;
      neg_im_q     <= neg_im_d;
      sat_re_q     <= sat_re_d;
      sat_im_q     <= sat_im_d;
      dz_flag_q    <= dz_flag_d;
      start_pend_q <= start_pend_d;
      res_q        <= res_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  complex_div_udiv_iter #(
    .P_MW(MW), .P_DW(DW), .P_NITER(NITER), .P_DSH(DSH)
  ) u_div_re (
    .clk  (clk),
    .rst  (rst),
    .start(start_c),
    .num  (mag_re_q),
    .den  (den_q),
    .busy (busy_re),
    .done (done_re),
    .quo  (quo_re)
  );

  complex_div_udiv_iter #(
    .P_MW(MW), .P_DW(DW), .P_NITER(NITER), .P_DSH(DSH)
  ) u_div_im (
    .clk  (clk),
    .rst  (rst),
    .start(start_c),
    .num  (mag_im_q),
    .den  (den_q),
    .busy (busy_im),
    .done (done_im),
    .quo  (quo_im)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign q_re      = res_q.q_re;
  assign q_im      = res_q.q_im;
  assign dz        = res_q.dz;
  assign ovf       = res_q.ovf;

endmodule

// File: tb/tb_complex_div.sv
// Scoreboard bench for complex_div: directed vectors push expectations, a monitor pops on output transfer.
module tb_complex_div;

`ifdef COMPLEX_DIV_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  localparam int LAT  = RND ? 18 : 17;
  localparam int LAT0 = 2;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, out_valid, out_ready;
  logic signed [15:0] a_re, a_im, b_re, b_im;
  logic signed [15:0] q_re, q_im;
  logic dz, ovf;

  typedef struct {
    logic signed [15:0] q_re;
    logic signed [15:0] q_im;
    logic               dz;
    logic               ovf;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_seen  = 0;

  always #5 clk = ~clk;

  complex_div dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_re     (a_re),
    .a_im     (a_im),
    .b_re     (b_re),
    .b_im     (b_im),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .q_re     (q_re),
    .q_im     (q_im),
    .dz       (dz),
    .ovf      (ovf)
  );

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares whenever a result transfer will happen on the coming edge
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got q=(%0d,%0d) with empty scoreboard", q_re, q_im);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("q_re", q_re, e.q_re);
        check("q_im", q_im, e.q_im);
        check("dz", dz, e.dz);
        check("ovf", ovf, e.ovf);
        n_seen++;
      end
    end
  end

  task automatic issue(input int ar, input int ai, input int br, input int bi);
    a_re = 16'(ar);
    a_im = 16'(ai);
    b_re = 16'(br);
    b_im = 16'(bi);
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    check("accept_timeout", 0, 1);
  endtask

  task automatic wait_result(input int lat);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid && n < 100);
    check("latency", n, lat);
  endtask

  task automatic push(input int eqr, input int eqi, input bit edz, input bit eovf);
    exp_t e;
    e.q_re = 16'(eqr);
    e.q_im = 16'(eqi);
    e.dz   = edz;
    e.ovf  = eovf;
    sb.push_back(e);
  endtask

  task automatic scramble();
    in_valid = 1'b0;
    a_re = 16'sh5a5a;
    a_im = -16'sd1234;
    b_re = 16'sd0;
    b_im = 16'sd0;
  endtask

  task automatic run(input int ar, input int ai, input int br, input int bi,
                     input int eqr, input int eqi, input bit edz, input bit eovf, input int lat);
    push(eqr, eqi, edz, eovf);
    issue(ar, ai, br, bi);
    scramble();
    wait_result(lat);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_q_re", q_re, 0);
    check("rst_q_im", q_im, 0);
    check("rst_dz", dz, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1);

    run(4, 2, 1, 1, 768, -256, 0, 0, LAT);
    run(-4, -2, 1, 1, -768, 256, 0, 0, LAT);
    run(-2, 0, 3, 0, RND ? -171 : -170, 0, 0, 0, LAT);
    run(2, 0, 3, 0, RND ? 171 : 170, 0, 0, 0, LAT);
    run(1, 0, 3, 0, 85, 0, 0, 0, LAT);
    run(5, 7, 0, 0, 0, 0, 1, 0, LAT0);
    run(32767, 0, 1, 0, 32767, 0, 0, 1, LAT);
    run(-32768, 32767, 1, 0, -32767, 32767, 0, 1, LAT0);
    run(0, 100, 0, -3, -8533, 0, 0, 0, LAT);
    run(32640, 64, 255, 1, 32767, -64, 0, RND, LAT);
    run(-1, 0, 512, 0, RND ? -1 : 0, 0, 0, 0, LAT);

    // Consumer stalls for 10 cycles: outputs must hold and no new accept
    out_ready = 1'b0;
    push(RND ? 171 : 170, 0, 0, 0);
    issue(2, 0, 3, 0);
    scramble();
    wait_result(LAT);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_out_valid", out_valid, 1);
      check("hold_q_re", q_re, RND ? 171 : 170);
      check("hold_dz_ovf", {dz, ovf}, 0);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);

    // Back-to-back requests: second waits for the first to be consumed
    push(768, -256, 0, 0);
    issue(4, 2, 1, 1);
    push(85, 0, 0, 0);
    seen0 = n_seen;
    issue(1, 0, 3, 0);
    check("b2b_first_done_before_accept", n_seen, seen0 + 1);
    scramble();
    wait_result(LAT);
    @(posedge clk); #1;

    // Reset during iteration aborts the operation
    issue(4, 2, 1, 1);
    scramble();
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_q_re", q_re, 0);
    check("abort_q_im", q_im, 0);
    check("abort_in_ready", in_ready, 1);
    repeat (25) @(posedge clk);
    #1;
    check("abort_no_result", out_valid, 0);

    run(4, 2, 1, 1, 768, -256, 0, 0, LAT);

    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
